// File: rtl/mult_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_pkg: op codes, FSM encoding and decode helpers for mult_div_unit.|
// | MULT_DIV_ACCUM_EN enables MADD/MADDU decode.  Rev 1.0                    |
// +--------------------------------------------------------------------------+
package mult_div_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER_CNT_W    = $clog2(DEFAULT_WIDTH) + 1;

    function automatic int iter_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

    function automatic logic op_is_madd(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU);
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
`ifdef MULT_DIV_ACCUM_EN
        return op <= OP_MADDU;
`else
        return op <= OP_DIVU;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_sign_fix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_sign_fix: turns magnitude results into signed {hi, lo}.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw_i,
    input  logic               sa_i,
    input  logic               sb_i,
    input  logic [2:0]         op_i,
    output logic [2*WIDTH-1:0] fixed_o
);

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // Divide results arrive as {remainder, quotient}; the remainder follows the dividend sign.
    assign rem      = raw_i[2*WIDTH-1:WIDTH];
    assign quo      = raw_i[WIDTH-1:0];
    assign quo_fix  = (sa_i ^ sb_i) ? -quo : quo;
    assign rem_fix  = sa_i ? -rem : rem;
    assign prod_fix = (sa_i ^ sb_i) ? -raw_i : raw_i;
    assign fixed_o  = op_is_div(op_i) ? {rem_fix, quo_fix} : prod_fix;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit: iterative multiply/divide owning HI/LO (one bit per cycle).|
// | MULT_DIV_ACCUM_EN adds MADD/MADDU accumulate.  Rev 1.0                   |
// +--------------------------------------------------------------------------+
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W     = iter_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               accept;
    logic               sgn_a;
    logic               sgn_b;
    logic               b_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] fixed;
    logic [2*WIDTH-1:0] hilo_d;

    assign accept = (state_q == ST_IDLE) && start && op_is_valid(op);
    assign sgn_a  = op_is_signed(op) && operand_a[WIDTH-1];
    assign sgn_b  = op_is_signed(op) && operand_b[WIDTH-1];
    assign mag_a  = sgn_a ? -operand_a : operand_a;
    assign mag_b  = sgn_b ? -operand_b : operand_b;
    assign b_zero = (operand_b == '0);

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opd_q};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opd_q};

    always_comb begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (op_is_div(op_q)) begin
            // Top bit of the trial difference is the borrow: set means restore.
            if (div_diff[WIDTH]) begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    mult_div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .raw_i   (acc_q),
        .sa_i    (sa_q),
        .sb_i    (sb_q),
        .op_i    (op_q),
        .fixed_o (fixed)
    );

`ifdef MULT_DIV_ACCUM_EN
    assign hilo_d = op_is_madd(op_q) ? ({hi_q, lo_q} + fixed) : fixed;
`else
    assign hilo_d = fixed;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opd_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            // Moves land first so a same-cycle operation result overwrites them.
            if (!busy_q && hi_we) hi_q <= wdata;
            if (!busy_q && lo_we) lo_q <= wdata;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        sa_q  <= sgn_a;
                        sb_q  <= sgn_b;
                        cnt_q <= '0;
                        if (op_is_div(op) && b_zero) begin
                            hi_q    <= operand_a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            opd_q   <= op_is_div(op) ? mag_b : mag_a;
                            acc_q   <= {{WIDTH{1'b0}}, op_is_div(op) ? mag_a : mag_b};
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    {hi_q, lo_q} <= hilo_d;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire
